// File: rtl/reg_pkg.sv
// Shared register-file constants and writeback requester ids.
// Used by the write arbiter and any block that names architectural regs.
package reg_pkg;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam logic [4:0] REG_HALT_CNT = 5'd24;
  localparam logic [4:0] REG_PC_SAVE  = 5'd25;
  localparam logic [4:0] REG_SPC      = 5'd26;
  localparam logic [4:0] REG_RA       = 5'd31;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;

  typedef enum logic [1:0] {
    DST_OK,
    DST_ZERO,
    DST_PROT
  } dst_kind_e;

  function automatic dst_kind_e dst_kind(
    input int unsigned addr,
    input int unsigned prot
  );
    if (addr == 0)
      return DST_ZERO;
    else if (addr == prot)
      return DST_PROT;
    else
      return DST_OK;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback request bundle and register-file write port.
// master = requesters/regfile side, slave = arbiter.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);

  logic [NUM_REQ-1:0]        Req_Valid;
  logic [NUM_REQ*ADDR_W-1:0] Req_Addr;
  logic [NUM_REQ*DATA_W-1:0] Req_Data;
  logic [NUM_REQ-1:0]        Req_Ready;
  logic                      Reg_Write;
  logic [ADDR_W-1:0]         Reg_escrita;
  logic [DATA_W-1:0]         Reg_dados;

  modport master (
    output Req_Valid, Req_Addr, Req_Data,
    input  Req_Ready,
    input  Reg_Write, Reg_escrita, Reg_dados
  );

  modport slave (
    input  Req_Valid, Req_Addr, Req_Data,
    output Req_Ready,
    output Reg_Write, Reg_escrita, Reg_dados
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first
// valid index strictly after last_i, wrapping modulo N.
module rr_picker #(
  parameter int N  = 3,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  grant_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port,
// dropping r0 writes and trapping writes to the protected slot.
module reg_write_arbiter
  import reg_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PROT_REG = 24,
  localparam int LW      = $clog2(NUM_REQ)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Hold,
  reg_write_arbiter_if.slave bus,
  output logic          Err_Prot,
  output logic [7:0]    Err_Count,
  output logic [LW-1:0] Grant_Last
);

  logic [NUM_REQ-1:0] pick;
  logic               accept;
  logic [LW-1:0]      g_idx;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [LW-1:0]     last_q, last_d;

  rr_picker #(.N(NUM_REQ), .LW(LW)) u_pick (
    .valid_i (bus.Req_Valid),
    .last_i  (last_q),
    .grant_o (pick)
  );

  // Ready ignores the destination: filtered writes are still retired
  assign bus.Req_Ready = (Hold || Reset) ? '0 : pick;
  assign accept        = |(bus.Req_Valid & bus.Req_Ready);

  always_comb begin
    g_idx  = '0;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.Req_Ready[i]) begin
        g_idx  = LW'(i);
        g_addr = bus.Req_Addr[i*ADDR_W +: ADDR_W];
        g_data = bus.Req_Data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (accept) begin
      last_d = g_idx;
      case (dst_kind(32'(g_addr), PROT_REG))
        DST_OK: begin
          wr_d   = 1'b1;
          addr_d = g_addr;
          data_d = g_data;
        end
        DST_PROT: begin
          err_d = 1'b1;
          if (cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= LW'(NUM_REQ - 1);
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign bus.Reg_Write   = wr_q;
  assign bus.Reg_escrita = addr_q;
  assign bus.Reg_dados   = data_q;
  assign Err_Prot        = err_q;
  assign Err_Count       = cnt_q;
  assign Grant_Last      = last_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scenario bench for reg_write_arbiter with a write scoreboard.
module tb_reg_write_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Hold;
  logic       Err_Prot;
  logic [7:0] Err_Count;
  logic [1:0] Grant_Last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  reg_write_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

  reg_write_arbiter #(
    .NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .PROT_REG(24)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Hold       (Hold),
    .bus        (bus),
    .Err_Prot   (Err_Prot),
    .Err_Count  (Err_Count),
    .Grant_Last (Grant_Last)
  );

  always #5 Clock = ~Clock;

  // every presented write must match the oldest expected one
  always @(negedge Clock) begin
    if (bus.Reg_Write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h",
                 bus.Reg_escrita, bus.Reg_dados);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.Reg_escrita !== e.a || bus.Reg_dados !== e.d) begin
          errors++;
          $display("FAIL write got=%0d:%h exp=%0d:%h",
                   bus.Reg_escrita, bus.Reg_dados, e.a, e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
    bus.Req_Valid[i]       = v;
    bus.Req_Addr[i*5 +: 5]  = a;
    bus.Req_Data[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs;
    bus.Req_Valid = '0;
    bus.Req_Addr  = '0;
    bus.Req_Data  = '0;
  endtask

  task automatic chk_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Hold  = 1'b0;
    clear_reqs();
    tick();
    tick();
    bus.Req_Valid = 3'b111;
    #1;
    checks++;
    if (bus.Req_Ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=000", bus.Req_Ready);
    end
    bus.Req_Valid = '0;
    checks++;
    if ({bus.Reg_Write, bus.Reg_escrita, bus.Reg_dados} !== 38'd0) begin
      errors++;
      $display("FAIL reset_wport got=%b/%0d/%h exp=0",
               bus.Reg_Write, bus.Reg_escrita, bus.Reg_dados);
    end
    checks++;
    if (Err_Prot !== 1'b0 || Err_Count !== 8'd0) begin
      errors++;
      $display("FAIL reset_err got=%b/%0d exp=0/0", Err_Prot, Err_Count);
    end
    checks++;
    if (Grant_Last !== 2'd2) begin
      errors++;
      $display("FAIL reset_last got=%0d exp=2", Grant_Last);
    end
    Reset = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [4:0]  ad [3] = '{5'd5, 5'd8, 5'd31};
    logic [31:0] dd [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    logic [2:0]  er;
    for (int k = 0; k < 3; k++)
      set_req(k, 1'b1, ad[k], dd[k]);
    for (int k = 0; k < 3; k++) begin
      #1;
      er = 3'b001 << k;
      checks++;
      if (bus.Req_Ready !== er) begin
        errors++;
        $display("FAIL rr_ready%0d got=%b exp=%b", k, bus.Req_Ready, er);
      end
      exp_q.push_back('{ad[k], dd[k]});
      tick();
      checks++;
      if (Grant_Last !== 2'(k)) begin
        errors++;
        $display("FAIL rr_last%0d got=%0d exp=%0d", k, Grant_Last, k);
      end
      bus.Req_Valid[k] = 1'b0;
    end
    tick();
    tick();
    chk_empty("rr_drain");
  endtask

  task automatic test_r0;
    clear_reqs();
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus.Req_Ready !== 3'b010) begin
      errors++;
      $display("FAIL r0_ready got=%b exp=010", bus.Req_Ready);
    end
    tick();
    clear_reqs();
    checks++;
    if (Grant_Last !== 2'd1 || bus.Reg_Write !== 1'b0) begin
      errors++;
      $display("FAIL r0_drop got=%0d/%b exp=1/0", Grant_Last, bus.Reg_Write);
    end
    tick();
  endtask

  task automatic test_prot;
    set_req(2, 1'b1, 5'd24, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.Req_Ready !== 3'b100) begin
      errors++;
      $display("FAIL prot_ready got=%b exp=100", bus.Req_Ready);
    end
    tick();
    tick();
    checks++;
    if (Err_Prot !== 1'b1 || Err_Count !== 8'd2 || bus.Reg_Write !== 1'b0) begin
      errors++;
      $display("FAIL prot_two got=%b/%0d/%b exp=1/2/0",
               Err_Prot, Err_Count, bus.Reg_Write);
    end
    repeat (298) tick();
    checks++;
    if (Err_Count !== 8'd255) begin
      errors++;
      $display("FAIL prot_sat got=%0d exp=255", Err_Count);
    end
    clear_reqs();
    tick();
    checks++;
    if (Err_Count !== 8'd255 || Err_Prot !== 1'b1) begin
      errors++;
      $display("FAIL prot_sticky got=%b/%0d exp=1/255", Err_Prot, Err_Count);
    end
  endtask

  task automatic test_hold;
    Hold = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h0000_1111);
    set_req(1, 1'b1, 5'd2, 32'h0000_2222);
    set_req(2, 1'b1, 5'd3, 32'h0000_3333);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.Req_Ready !== 3'b000) begin
        errors++;
        $display("FAIL hold_ready%0d got=%b exp=000", c, bus.Req_Ready);
      end
      tick();
      checks++;
      if (bus.Reg_Write !== 1'b0) begin
        errors++;
        $display("FAIL hold_wr%0d got=%b exp=0", c, bus.Reg_Write);
      end
    end
    Hold = 1'b0;
    #1;
    checks++;
    if (bus.Req_Ready !== 3'b001) begin
      errors++;
      $display("FAIL hold_resume got=%b exp=001", bus.Req_Ready);
    end
    exp_q.push_back('{5'd1, 32'h0000_1111});
    tick();
    clear_reqs();
    checks++;
    if (Grant_Last !== 2'd0) begin
      errors++;
      $display("FAIL hold_last got=%0d exp=0", Grant_Last);
    end
    tick();
    tick();
    chk_empty("hold_drain");
  endtask

  task automatic test_reset_mid;
    set_req(0, 1'b1, 5'd9, 32'h1234_5678);
    #1;
    checks++;
    if (bus.Req_Ready !== 3'b001) begin
      errors++;
      $display("FAIL rmid_ready got=%b exp=001", bus.Req_Ready);
    end
    // the accepted write is still presented for the cycle before reset lands
    exp_q.push_back('{5'd9, 32'h1234_5678});
    tick();
    clear_reqs();
    Reset = 1'b1;
    tick();
    checks++;
    if (bus.Reg_Write !== 1'b0 || Grant_Last !== 2'd2) begin
      errors++;
      $display("FAIL rmid_state got=%b/%0d exp=0/2", bus.Reg_Write, Grant_Last);
    end
    checks++;
    if (Err_Prot !== 1'b0 || Err_Count !== 8'd0) begin
      errors++;
      $display("FAIL rmid_err got=%b/%0d exp=0/0", Err_Prot, Err_Count);
    end
    Reset = 1'b0;
    tick();
    chk_empty("rmid_drain");
  endtask

  task automatic test_fairness;
    logic [2:0] er;
    set_req(0, 1'b1, 5'd10, 32'hA0A0_0010);
    set_req(2, 1'b1, 5'd12, 32'hC0C0_0012);
    for (int c = 0; c < 10; c++) begin
      #1;
      er = (c % 2 == 0) ? 3'b001 : 3'b100;
      checks++;
      if (bus.Req_Ready !== er) begin
        errors++;
        $display("FAIL fair_ready%0d got=%b exp=%b", c, bus.Req_Ready, er);
      end
      if (c % 2 == 0)
        exp_q.push_back('{5'd10, 32'hA0A0_0010});
      else
        exp_q.push_back('{5'd12, 32'hC0C0_0012});
      tick();
    end
    clear_reqs();
    tick();
    tick();
    chk_empty("fair_drain");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_r0();
    test_prot();
    test_hold();
    test_reset_mid();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
